// File: rtl/boot_sequencer.sv
// Boot loader for the RV32I core: holds the core in reset, writes a length-prefixed
// little-endian byte stream into instruction memory, then releases the core at PC 0.
`timescale 1ns/1ps

module boot_sequencer #(
  parameter int unsigned IMEM_WORDS     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        core_reset,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_FINISH,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic [16:0] MAX_WORDS     = 17'(IMEM_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] word_index;
  logic [1:0]  byte_index;
  logic [23:0] partial;
  logic [31:0] idle_count;

  logic        transfer;
  logic        timeout_hit;
  logic        len_bad;
  logic [15:0] len_next;

  assign rx_ready    = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
  assign busy        = rx_ready || (state == ST_FINISH);
  assign transfer    = rx_valid && rx_ready;
  assign len_next    = {rx_data, len_lo};
  assign len_bad     = (len_next == 16'd0) || ({1'b0, len_next} > MAX_WORDS);
  // Fires on the idle cycle that would bring the counter up to the limit.
  assign timeout_hit = (TIMEOUT_LIMIT != 32'd0) && ((idle_count + 32'd1) == TIMEOUT_LIMIT);

  // NOTE: every state register is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LEN_LO;
      core_reset <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      error      <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      word_index <= '0;
      byte_index <= '0;
      partial    <= '0;
      idle_count <= '0;
    end else begin
      // NOTE: the write strobe defaults low each cycle, which makes it a one-cycle pulse.
      imem_we <= 1'b0;
      case (state)
        ST_LEN_LO: begin
          if (transfer) begin
            len_lo     <= rx_data;
            idle_count <= '0;
            state      <= ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          if (transfer) begin
            len        <= len_next;
            idle_count <= '0;
            if (len_bad) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              word_index <= '0;
              byte_index <= '0;
              state      <= ST_DATA;
            end
          end else if (timeout_hit) begin
            idle_count <= '0;
            state      <= ST_ERROR;
            error      <= 1'b1;
          end else begin
            idle_count <= idle_count + 32'd1;
          end
        end

        ST_DATA: begin
          if (transfer) begin
            idle_count <= '0;
            byte_index <= byte_index + 2'd1;
            partial    <= {rx_data, partial[23:8]};
            if (byte_index == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= {14'b0, word_index, 2'b00};
              imem_wdata <= {rx_data, partial};
              word_index <= word_index + 16'd1;
              if ((word_index + 16'd1) == len) begin
                state <= ST_FINISH;
              end
            end
          end else if (timeout_hit) begin
            idle_count <= '0;
            state      <= ST_ERROR;
            error      <= 1'b1;
          end else begin
            idle_count <= idle_count + 32'd1;
          end
        end

        ST_FINISH: begin
          state <= ST_RUN;
        end

        ST_RUN: begin
          core_reset <= 1'b0;
          if (boot_start) begin
            core_reset <= 1'b1;
            word_index <= '0;
            byte_index <= '0;
            idle_count <= '0;
            state      <= ST_LEN_LO;
          end
        end

        ST_ERROR: begin
          if (boot_start) begin
            error      <= 1'b0;
            word_index <= '0;
            byte_index <= '0;
            idle_count <= '0;
            state      <= ST_LEN_LO;
          end
        end

        default: begin
          state <= ST_LEN_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: image loads, gapped streams, timeout,
// length limits, re-arm from RUN/ERROR and asynchronous reset mid-load.
`timescale 1ns/1ps

module tb_boot_sequencer;

  logic        clk;
  logic        reset;
  logic        boot_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        core_reset;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  img[$];
  logic        prev_we = 1'b0;
  int          back_to_back = 0;

  boot_sequencer #(
    .IMEM_WORDS    (1024),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .boot_start(boot_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .core_reset(core_reset),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      if (prev_we) back_to_back++;
    end
    prev_we = imem_we;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte; the sequencer must already be ready for it.
  task automatic send_byte(input logic [7:0] b);
    check("rx_ready_on_send", {31'b0, rx_ready}, 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Send img[] with up to gap_max idle cycles before each byte.
  task automatic send_img(input int gap_max);
    for (int i = 0; i < img.size(); i++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(0, gap_max);
        for (int c = 0; c < g; c++) begin
          rx_data  = 8'($urandom);
          rx_valid = 1'b0;
          tick(1);
        end
      end
      send_byte(img[i]);
    end
  endtask

  task automatic pulse_boot;
    boot_start = 1'b1;
    tick(1);
    boot_start = 1'b0;
  endtask

  task automatic flush_writes;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic load_basic(input int gap_max, input string tag);
    flush_writes();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_img(gap_max);
    check({tag, "_we_after_last"}, {31'b0, imem_we}, 32'd1);
    check({tag, "_core_reset_k1"}, {31'b0, core_reset}, 32'd1);
    tick(1);
    check({tag, "_core_reset_k2m"}, {31'b0, core_reset}, 32'd1);
    tick(1);
    check({tag, "_flags_run"}, {28'b0, core_reset, busy, error, rx_ready}, 32'b0000);
    check({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check({tag, "_addr0"}, wr_addr_q[0], 32'h0);
      check({tag, "_data0"}, wr_data_q[0], 32'h0000_0013);
      check({tag, "_addr1"}, wr_addr_q[1], 32'h4);
      check({tag, "_data1"}, wr_data_q[1], 32'h0010_0093);
    end
  endtask

  initial begin
    int bad;
    reset      = 1'b1;
    boot_start = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;

    // Reset values.
    #12;
    check("reset_flags", {27'b0, core_reset, imem_we, busy, error, rx_ready}, 32'b10101);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_wdata", imem_wdata, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("idle_len_lo_no_timeout", {30'b0, error, rx_ready}, 32'b01);

    // Basic load, then bytes in RUN are ignored.
    load_basic(0, "basic");
    flush_writes();
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    tick(3);
    rx_valid = 1'b0;
    check("run_ignores_bytes", {29'b0, core_reset, busy, rx_ready}, 32'b000);
    check("run_no_writes", 32'(wr_addr_q.size()), 32'd0);

    // Re-arm from RUN with a one-word image.
    pulse_boot();
    check("rearm_run_flags", {29'b0, core_reset, busy, rx_ready}, 32'b111);
    flush_writes();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_img(0);
    tick(2);
    check("rearm_core_reset", {31'b0, core_reset}, 32'd0);
    check("rearm_write_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("rearm_addr", wr_addr_q[0], 32'h0);
      check("rearm_data", wr_data_q[0], 32'hDEAD_BEEF);
    end

    // Gapped stream, gaps below the timeout.
    pulse_boot();
    load_basic(40, "gapped");

    // Timeout: a transfer on the limit cycle wins, then a real stall errors out.
    pulse_boot();
    flush_writes();
    img = '{8'h01, 8'h00};
    send_img(0);
    tick(49);
    send_byte(8'hAA);
    check("tie_transfer_wins", {30'b0, error, busy}, 32'b01);
    tick(49);
    check("timeout_49_idle", {30'b0, error, busy}, 32'b01);
    tick(1);
    check("timeout_50_idle", {28'b0, error, core_reset, rx_ready, busy}, 32'b1100);
    tick(5);
    check("error_sticky", {30'b0, error, core_reset}, 32'b11);
    pulse_boot();
    check("error_cleared", {29'b0, error, rx_ready, core_reset}, 32'b011);

    // Bad lengths.
    img = '{8'h00, 8'h00};
    send_img(0);
    check("len_zero_error", {30'b0, error, rx_ready}, 32'b10);
    check("len_zero_no_write", 32'(wr_addr_q.size()), 32'd0);
    pulse_boot();
    img = '{8'h01, 8'h04};
    send_img(0);
    check("len_1025_error", {30'b0, error, rx_ready}, 32'b10);
    pulse_boot();

    // Full-depth image of 1024 words.
    flush_writes();
    img = '{8'h00, 8'h04};
    send_img(0);
    check("len_1024_accepted", {30'b0, error, rx_ready}, 32'b01);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = 16'(i);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(8'h5A);
      send_byte(8'hA5);
    end
    tick(2);
    check("full_core_reset", {30'b0, core_reset, error}, 32'b00);
    check("full_write_count", 32'(wr_addr_q.size()), 32'd1024);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      logic [15:0] w;
      w = 16'(i);
      if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== {8'hA5, 8'h5A, w[15:8], w[7:0]})
        bad++;
    end
    check("full_bad_words", 32'(bad), 32'd0);
    if (wr_addr_q.size() == 1024) begin
      check("full_last_addr", wr_addr_q[1023], 32'h0000_0FFC);
      check("full_last_data", wr_data_q[1023], 32'hA55A_03FF);
    end

    // Asynchronous reset after five data bytes.
    pulse_boot();
    img = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_img(0);
    #2;
    reset = 1'b1;
    #1;
    check("midload_reset_flags", {27'b0, core_reset, imem_we, busy, error, rx_ready}, 32'b10101);
    check("midload_reset_addr", imem_addr, 32'h0);
    check("midload_reset_wdata", imem_wdata, 32'h0);
    tick(1);
    reset = 1'b0;
    flush_writes();
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_img(0);
    tick(2);
    check("reload_core_reset", {31'b0, core_reset}, 32'd0);
    check("reload_write_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("reload_addr", wr_addr_q[0], 32'h0);
      check("reload_data", wr_data_q[0], 32'h4433_2211);
    end

    check("no_back_to_back_we", 32'(back_to_back), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Boot-time controller for the single-cycle RV32I core.
- Holds the core in reset and receives a program image as a byte stream from a UART/debug receiver.
- Writes the image word by word into instruction memory through a dedicated write port, then releases the core to execute from PC 0.
- Detects malformed images and stalled streams. It can be re-armed for a reload without a global reset.

Parameters:
IMEM_WORDS, 1024, instruction memory depth in 32-bit words; maximum accepted image length.
TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted bytes once a load has begun; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
boot_start  input  1  single-cycle pulse; re-arms a load from RUN or ERROR.
rx_data  input  8  incoming image byte.
rx_valid  input  1  rx_data valid.
rx_ready  output  1  sequencer can accept a byte; a transfer occurs on a cycle with rx_valid & rx_ready.
core_reset  output  1  drives the core's reset; high while loading or in error.
imem_we  output  1  instruction memory write strobe, one cycle per word.
imem_addr  output  32  byte address of the word being written (word_index*4).
imem_wdata  output  32  assembled instruction word.
busy  output  1  load in progress (states LEN_LO, LEN_HI, DATA, FINISH).
error  output  1  sticky until re-armed; load failed.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high; all registers clear immediately when reset asserts.
- Reset values: state=LEN_LO, core_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, error=0, byte/word/timeout counters=0.
- rx_ready is combinational from state: 1 in LEN_LO, LEN_HI and DATA; 0 otherwise.
- Stream format:
  - 2-byte word count N, little-endian (LEN_LO byte first).
  - Then N*4 bytes. Each word is little-endian: the first byte goes to wdata[7:0].
- States and transitions:
  - LEN_LO: on transfer, store N[7:0] -> LEN_HI.
  - LEN_HI: on transfer, store N[15:8]. If N==0 or N>IMEM_WORDS -> ERROR; else -> DATA with word_index=0 and byte_index=0.
  - DATA: on transfer, shift the byte into the word register and increment byte_index (mod 4). On the 4th byte, register imem_we=1, imem_addr=word_index*4 and imem_wdata=the assembled word for exactly the next cycle, then increment word_index. If that was word N-1 -> FINISH; else stay in DATA.
  - FINISH: one cycle in which the final write is presented; -> RUN.
  - RUN: core_reset=0, busy=0, rx_ready=0. Bytes arriving in RUN are ignored. boot_start -> LEN_LO with core_reset=1, counters cleared.
  - ERROR: core_reset=1, error=1, rx_ready=0. boot_start -> LEN_LO and clears error.
- boot_start is ignored in LEN_LO, LEN_HI, DATA and FINISH.
- Latency: if the last byte is accepted at edge k, imem_we is high during cycle k..k+1 and core_reset falls at edge k+2. The core therefore never sees an instruction fetch while a write is pending.
- imem_we is never high in two consecutive cycles, because a word needs at least 4 transfers. imem_addr and imem_wdata hold their last values when imem_we=0.
- Timeout:
  - The counter increments every cycle in LEN_HI or DATA without a transfer, and clears on each transfer and on every state entry.
  - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0) -> ERROR.
  - No timeout applies in LEN_LO; the sequencer waits indefinitely for the first byte.
- Simultaneous events: if a transfer and a timeout occur in the same cycle, the transfer wins and the counter clears.
- Reset mid-load: an asynchronous return to LEN_LO. Partially written memory is not cleared; the next image overwrites it.
- Arithmetic: word_index is 16 bits. imem_addr = {14'b0, word_index, 2'b00}. Lengths use an unsigned compare against IMEM_WORDS.

Test Plan:
- Basic load: after reset, send 02 00 13 00 00 00 93 00 10 00 -> imem_we pulses twice, (addr 0x0, data 0x00000013) then (addr 0x4, data 0x00100093). core_reset falls 2 cycles after the last byte; busy=0, error=0.
- Gapped stream with rx_valid toggling randomly, TIMEOUT_CYCLES=50, gaps ≤40 cycles -> identical writes and no error.
- Timeout: TIMEOUT_CYCLES=50; send 01 00 AA then stall -> error=1 after exactly 50 idle cycles, core_reset stays 1, rx_ready=0. A boot_start pulse clears error and returns rx_ready=1.
- Bad length:
  - Send 00 00 -> ERROR with no imem_we.
  - With IMEM_WORDS=1024, send 01 04 (N=1025) -> ERROR.
  - Send 00 04 (N=1024) -> accepted; last write at addr 0xFFC.
- Re-arm from RUN: complete a load, pulse boot_start -> core_reset=1 the next cycle. A new 1-word image 01 00 EF BE AD DE writes 0xDEADBEEF at addr 0x0, then core_reset falls.
- Reset mid-load: assert reset after 5 data bytes -> outputs return to reset values asynchronously. After deassertion, a fresh image loads from address 0.
